// File: rtl/reg_file_pkg.sv
// reg_file_pkg: default geometry and clear-FSM state encoding for the 2R1W register file.
package reg_file_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_ADDR_W = 3;
  typedef enum logic {IDLE = 1'b0, CLEARING = 1'b1} clr_state_t;
endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one read port -- range check, write-first bypass merge, registered output.
module reg_file_rd_port #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  mem_data,
  input  logic              wr_hit,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  output logic [WIDTH-1:0]  data,
  output logic              valid,
  output logic              err
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  logic oor;
  logic [WIDTH-1:0] merged;
  always_comb begin
    oor = {1'b0, addr} >= DEPTH_L;
    err = en && oor;
    merged = mem_data;
    for (int i = 0; i < WIDTH/8; i++)
      merged[8*i+:8] = (wr_hit && wr_be[i]) ? wr_data[8*i+:8] : mem_data[8*i+:8];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data <= '0;
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en) data <= oor ? '0 : merged;
    end
endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: byte-enabled 2-read/1-write register file with sequential clear and sticky range error.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               WR_EN,
  input  logic [ADDR_W-1:0]  WR_ADDR,
  input  logic [WIDTH-1:0]   WR_DATA,
  input  logic [WIDTH/8-1:0] WR_BE,
  input  logic               RD_EN_A,
  input  logic               RD_EN_B,
  input  logic [ADDR_W-1:0]  RD_ADDR_A,
  input  logic [ADDR_W-1:0]  RD_ADDR_B,
  output logic [WIDTH-1:0]   RD_DATA_A,
  output logic [WIDTH-1:0]   RD_DATA_B,
  output logic               RD_VALID_A,
  output logic               RD_VALID_B,
  input  logic               CLR,
  output logic               BUSY,
  output logic               ERR
);
  localparam int NB = WIDTH/8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);
  logic [WIDTH-1:0] mem [DEPTH];
  clr_state_t state;
  logic [ADDR_W-1:0] clr_idx;
  logic idle, wr_oor, wr_ok, rd_a, rd_b, err_a, err_b, hit_a, hit_b;
  logic [WIDTH-1:0] mem_a, mem_b;
  always_comb begin
    idle = state == IDLE;
    wr_oor = {1'b0, WR_ADDR} >= DEPTH_L;
    wr_ok = idle && WR_EN && !CLR && !wr_oor;
    rd_a = idle && RD_EN_A;
    rd_b = idle && RD_EN_B;
    hit_a = wr_ok && WR_ADDR == RD_ADDR_A;
    hit_b = wr_ok && WR_ADDR == RD_ADDR_B;
    mem_a = mem[RD_ADDR_A];
    mem_b = mem[RD_ADDR_B];
  end
  // Starting a clear wipes ERR, but a range error seen at that same edge is still recorded.
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= IDLE;
      clr_idx <= '0;
      BUSY <= 1'b0;
      ERR <= 1'b0;
    end else if (idle) begin
      if (CLR) begin
        state <= CLEARING;
        clr_idx <= '0;
        BUSY <= 1'b1;
      end
      ERR <= (ERR && !CLR) | (WR_EN && !CLR && wr_oor) | err_a | err_b;
    end else begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == LAST) begin
        state <= IDLE;
        BUSY <= 1'b0;
      end
    end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!idle) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      for (int b = 0; b < NB; b++)
        if (WR_BE[b]) mem[WR_ADDR][8*b+:8] <= WR_DATA[8*b+:8];
    end
  reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_a (
    .clk(CLK), .rst_n(RST), .en(rd_a), .addr(RD_ADDR_A), .mem_data(mem_a),
    .wr_hit(hit_a), .wr_data(WR_DATA), .wr_be(WR_BE),
    .data(RD_DATA_A), .valid(RD_VALID_A), .err(err_a)
  );
  reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_b (
    .clk(CLK), .rst_n(RST), .en(rd_b), .addr(RD_ADDR_B), .mem_data(mem_b),
    .wr_hit(hit_b), .wr_data(WR_DATA), .wr_be(WR_BE),
    .data(RD_DATA_B), .valid(RD_VALID_B), .err(err_b)
  );
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: scenario tasks plus randomized traffic against an array model of the register file.
module tb_reg_file_2r1w;
  logic CLK = 0, RST = 1, WR_EN = 0, RD_EN_A = 0, RD_EN_B = 0, CLR = 0;
  logic [2:0] WR_ADDR = 0, RD_ADDR_A = 0, RD_ADDR_B = 0;
  logic [15:0] WR_DATA = 0;
  logic [1:0] WR_BE = 0;
  logic [15:0] rd_a, rd_b, rd6_a, rd6_b;
  logic va, vb, busy, err, va6, vb6, busy6, err6;
  int total = 0, bad = 0;
  logic [15:0] m [8];
  logic [15:0] ea, eb;

  always #5 CLK = ~CLK;

  reg_file_2r1w dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_BE(WR_BE),
    .RD_EN_A(RD_EN_A), .RD_EN_B(RD_EN_B), .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B),
    .RD_DATA_A(rd_a), .RD_DATA_B(rd_b), .RD_VALID_A(va), .RD_VALID_B(vb),
    .CLR(CLR), .BUSY(busy), .ERR(err)
  );
  reg_file_2r1w #(.WIDTH(16), .DEPTH(6), .ADDR_W(3)) dut6 (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_BE(WR_BE),
    .RD_EN_A(RD_EN_A), .RD_EN_B(RD_EN_B), .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B),
    .RD_DATA_A(rd6_a), .RD_DATA_B(rd6_b), .RD_VALID_A(va6), .RD_VALID_B(vb6),
    .CLR(CLR), .BUSY(busy6), .ERR(err6)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    WR_EN = 0; RD_EN_A = 0; RD_EN_B = 0; CLR = 0; WR_BE = 0;
  endtask

  task automatic mwr(input int a, input logic [15:0] d, input logic [1:0] be);
    for (int b = 0; b < 2; b++) if (be[b]) m[a][8*b+:8] = d[8*b+:8];
  endtask

  task automatic mclr();
    for (int i = 0; i < 8; i++) m[i] = 16'h0;
  endtask

  task automatic wr(input int a, input logic [15:0] d, input logic [1:0] be);
    WR_EN = 1; WR_ADDR = 3'(a); WR_DATA = d; WR_BE = be;
    tick();
    WR_EN = 0;
    mwr(a, d, be);
  endtask

  task automatic test_reset();
    tick();
    RST = 0;
    #1;
    total++;
    if ({rd_a, rd_b, va, vb, busy, err} !== 36'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {rd_a, rd_b, va, vb, busy, err});
    end
    RST = 1;
    mclr();
    RD_EN_A = 1; RD_ADDR_A = 0; RD_EN_B = 1; RD_ADDR_B = 7;
    tick();
    idle();
    total++;
    if (rd_a !== 16'h0 || va !== 1'b1) begin
      bad++; $display("FAIL reset_read_a got=%h/%b want=0000/1", rd_a, va);
    end
    total++;
    if (rd_b !== 16'h0 || vb !== 1'b1) begin
      bad++; $display("FAIL reset_read_b got=%h/%b want=0000/1", rd_b, vb);
    end
    tick();
    total++;
    if (va !== 1'b0 || vb !== 1'b0) begin
      bad++; $display("FAIL valid_pulse got=%b%b want=00", va, vb);
    end
  endtask

  task automatic test_byte_en();
    wr(1, 16'hFFFF, 2'b11);
    wr(1, 16'h0000, 2'b01);
    wr(1, 16'h1234, 2'b00);
    RD_EN_A = 1; RD_ADDR_A = 1;
    tick();
    idle();
    total++;
    if (rd_a !== 16'hFF00 || va !== 1'b1) begin
      bad++; $display("FAIL byte_en got=%h/%b want=ff00/1", rd_a, va);
    end
    tick();
    total++;
    if (rd_a !== 16'hFF00 || va !== 1'b0) begin
      bad++; $display("FAIL data_hold got=%h/%b want=ff00/0", rd_a, va);
    end
  endtask

  task automatic test_bypass();
    WR_EN = 1; WR_ADDR = 2; WR_DATA = 16'h1234; WR_BE = 2'b11;
    RD_EN_A = 1; RD_ADDR_A = 2; RD_EN_B = 1; RD_ADDR_B = 2;
    tick();
    idle();
    mwr(2, 16'h1234, 2'b11);
    total++;
    if (rd_a !== 16'h1234 || rd_b !== 16'h1234 || !va || !vb) begin
      bad++; $display("FAIL bypass got=%h/%h want=1234/1234", rd_a, rd_b);
    end
  endtask

  task automatic test_random();
    ea = 16'h1234; eb = 16'h1234;
    for (int n = 0; n < 300; n++) begin
      WR_EN = 1'($urandom); WR_ADDR = 3'($urandom); WR_DATA = 16'($urandom); WR_BE = 2'($urandom);
      RD_EN_A = 1'($urandom); RD_ADDR_A = 3'($urandom);
      RD_EN_B = 1'($urandom); RD_ADDR_B = ($urandom_range(0, 3) == 0) ? WR_ADDR : 3'($urandom);
      if (WR_EN) mwr(int'(WR_ADDR), WR_DATA, WR_BE);
      if (RD_EN_A) ea = m[RD_ADDR_A];
      if (RD_EN_B) eb = m[RD_ADDR_B];
      tick();
      total++;
      if (rd_a !== ea || va !== RD_EN_A) begin
        bad++; $display("FAIL rand_a n=%0d got=%h/%b want=%h/%b", n, rd_a, va, ea, RD_EN_A);
      end
      total++;
      if (rd_b !== eb || vb !== RD_EN_B) begin
        bad++; $display("FAIL rand_b n=%0d got=%h/%b want=%h/%b", n, rd_b, vb, eb, RD_EN_B);
      end
      total++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL rand_flags n=%0d got=%b%b want=00", n, err, busy);
      end
    end
    idle();
  endtask

  task automatic test_oor();
    RST = 0; #1; RST = 1;
    mclr();
    for (int i = 0; i < 6; i++) wr(i, 16'(16'h1111 * (i + 1)), 2'b11);
    wr(6, 16'hBEEF, 2'b11);
    total++;
    if (err6 !== 1'b1 || err !== 1'b0) begin
      bad++; $display("FAIL oor_write_err got=%b/%b want=1/0", err6, err);
    end
    RD_EN_A = 1; RD_ADDR_A = 6;
    tick();
    idle();
    total++;
    if (rd6_a !== 16'h0 || va6 !== 1'b1 || err6 !== 1'b1) begin
      bad++; $display("FAIL oor_read got=%h/%b/%b want=0000/1/1", rd6_a, va6, err6);
    end
    total++;
    if (rd_a !== 16'hBEEF) begin
      bad++; $display("FAIL inrange_6 got=%h want=beef", rd_a);
    end
    for (int i = 0; i < 6; i++) begin
      RD_EN_A = 1; RD_ADDR_A = 3'(i); RD_EN_B = 1; RD_ADDR_B = 3'(i);
      tick();
      total++;
      if (rd6_a !== 16'(16'h1111 * (i + 1)) || rd6_b !== rd6_a) begin
        bad++; $display("FAIL oor_untouched i=%0d got=%h/%h want=%h", i, rd6_a, rd6_b, 16'(16'h1111 * (i + 1)));
      end
    end
    idle();
    CLR = 1;
    tick();
    CLR = 0;
    total++;
    if (err6 !== 1'b0 || busy6 !== 1'b1) begin
      bad++; $display("FAIL clr_err got=%b/%b want=0/1", err6, busy6);
    end
    for (int i = 0; i < 8; i++) tick();
    mclr();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 8; i++) wr(i, 16'hA5A5, 2'b11);
    CLR = 1; WR_EN = 1; WR_ADDR = 3; WR_DATA = 16'h0F0F; WR_BE = 2'b11;
    RD_EN_A = 1; RD_ADDR_A = 3;
    tick();
    total++;
    if (busy !== 1'b1 || va !== 1'b1 || rd_a !== 16'hA5A5) begin
      bad++; $display("FAIL clr_start got=%b/%b/%h want=1/1/a5a5", busy, va, rd_a);
    end
    WR_DATA = 16'hFFFF; RD_EN_B = 1; RD_ADDR_B = 5;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (busy !== (k < 8) || va !== 1'b0 || vb !== 1'b0) begin
        bad++; $display("FAIL clr_busy k=%0d got=%b/%b%b want=%b/00", k, busy, va, vb, k < 8);
      end
    end
    idle();
    mclr();
    for (int i = 0; i < 8; i++) begin
      RD_EN_A = 1; RD_ADDR_A = 3'(i); RD_EN_B = 1; RD_ADDR_B = 3'(7 - i);
      tick();
      total++;
      if (rd_a !== m[i] || rd_b !== m[7-i] || !va || !vb || busy) begin
        bad++; $display("FAIL clr_after i=%0d got=%h/%h/%b want=0000/0000/0", i, rd_a, rd_b, busy);
      end
    end
    idle();
  endtask

  task automatic test_rst_abort();
    int n;
    for (int i = 0; i < 8; i++) wr(i, 16'($urandom) | 16'h0101, 2'b11);
    CLR = 1; RD_EN_A = 1; RD_ADDR_A = 5;
    tick();
    idle();
    total++;
    if (rd_a !== m[5] || busy !== 1'b1) begin
      bad++; $display("FAIL abort_pre got=%h/%b want=%h/1", rd_a, busy, m[5]);
    end
    tick(); tick(); tick();
    #2;
    RST = 0;
    #1;
    total++;
    if ({rd_a, rd_b, va, vb, busy, err} !== 36'h0) begin
      bad++; $display("FAIL abort_outputs got=%h want=0", {rd_a, rd_b, va, vb, busy, err});
    end
    RST = 1;
    mclr();
    RD_EN_A = 1; RD_ADDR_A = 5;
    tick();
    idle();
    total++;
    if (rd_a !== m[5] || va !== 1'b1) begin
      bad++; $display("FAIL abort_zeroed got=%h/%b want=0000/1", rd_a, va);
    end
    CLR = 1;
    tick();
    CLR = 0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL abort_reclr got=%b want=1", busy);
    end
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n !== 8) begin
      bad++; $display("FAIL abort_len got=%0d want=8", n);
    end
  endtask

  initial begin
    test_reset();
    test_byte_en();
    test_bypass();
    test_random();
    test_oor();
    test_clear();
    test_rst_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_file_2r1w.md
REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries; legal values are 2..256, power of two not required.
REQ-003 SHALL have parameter ADDR_W, default 3, address width; SHALL satisfy 2^ADDR_W >= DEPTH.
REQ-004 SHALL have port CLK  input  1  single clock, rising-edge active.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port WR_EN  input  1  write request, sampled at CLK rise.
REQ-007 SHALL have port WR_ADDR  input  ADDR_W  write address.
REQ-008 SHALL have port WR_DATA  input  WIDTH  write data.
REQ-009 SHALL have port WR_BE  input  WIDTH/8  byte enables; bit i covers WR_DATA[8i+7:8i].
REQ-010 SHALL have ports RD_EN_A / RD_EN_B  input  1  read requests, ports A and B.
REQ-011 SHALL have ports RD_ADDR_A / RD_ADDR_B  input  ADDR_W  read addresses.
REQ-012 SHALL have ports RD_DATA_A / RD_DATA_B  output  WIDTH  registered read data.
REQ-013 SHALL have ports RD_VALID_A / RD_VALID_B  output  1  one-cycle pulse qualifying read data.
REQ-014 SHALL have port CLR  input  1  request to zero all entries.
REQ-015 SHALL have port BUSY  output  1  high while a clear sequence runs.
REQ-016 SHALL have port ERR  output  1  sticky out-of-range address flag.

Function
REQ-017 A read SHALL have latency 1: RD_EN_x high at edge N gives RD_DATA_x and RD_VALID_x=1 after edge N+1.
REQ-018 RD_VALID_x SHALL be 0 in any cycle not following an accepted read; RD_DATA_x SHALL hold its last value when no read is accepted.
REQ-019 A write SHALL update only the bytes of entry WR_ADDR whose WR_BE bit is 1; all other bytes SHALL be unchanged; WR_BE=0 SHALL be a no-op.
REQ-020 A read and a write to the same address at the same edge SHALL return the merged post-write value (write-first bypass), per port independently.
REQ-021 Ports A and B SHALL be fully independent; identical addresses on both SHALL return identical data.
REQ-022 A write with WR_ADDR >= DEPTH SHALL be discarded and SHALL set ERR.
REQ-023 A read with RD_ADDR_x >= DEPTH SHALL return all-zero data with RD_VALID_x=1 and SHALL set ERR.
REQ-024 ERR SHALL stay 1 until reset or the start of a clear sequence.
REQ-025 Clear FSM SHALL have states IDLE and CLEARING; CLR=1 at an edge in IDLE SHALL move to CLEARING with clear index 0.
REQ-026 In CLEARING, one entry per cycle SHALL be zeroed in index order 0..DEPTH-1; after entry DEPTH-1 the FSM SHALL return to IDLE; sequence length is exactly DEPTH cycles.
REQ-027 BUSY SHALL be 1 exactly while in CLEARING.
REQ-028 While BUSY=1, WR_EN, RD_EN_A, RD_EN_B and CLR SHALL be ignored (no write, no RD_VALID pulse, no restart).
REQ-029 CLR and WR_EN asserted at the same edge in IDLE: CLR SHALL take effect and the write SHALL be dropped; reads at that edge SHALL still complete.

Reset
REQ-030 RST low SHALL asynchronously zero all entries, RD_DATA_A/B, RD_VALID_A/B, BUSY, ERR and the clear index, and force IDLE.
REQ-031 RST low during CLEARING SHALL abort the sequence immediately; after release the block SHALL be in IDLE.

Structure
REQ-032 Package reg_file_pkg SHALL hold default WIDTH/DEPTH/ADDR_W and the clear-FSM state encoding.
REQ-033 One sub-module reg_file_rd_port (address check, bypass merge, output register) SHALL be instantiated twice, for ports A and B.

Verification
REQ-034 Reset then read A addr 0, B addr 7 -> both RD_DATA=0x0000, RD_VALID=1 one cycle later.
REQ-035 Write addr 1 data 0xFFFF BE=11, then write addr 1 data 0x0000 BE=01, read A addr 1 -> 0xFF00.
REQ-036 Same edge: write addr 2 data 0x1234 BE=11, read A and B addr 2 -> both 0x1234 next cycle.
REQ-037 DEPTH=6: write addr 6, then read A addr 6 -> ERR=1, RD_DATA_A=0x0000, no entry altered; CLR then clears ERR.
REQ-038 Fill all 8 entries with 0xA5A5, pulse CLR with simultaneous write addr 3 -> BUSY=1 for 8 cycles, reads ignored, afterwards all entries 0x0000.
REQ-039 Assert RST after 3 cycles of CLEARING -> BUSY=0 immediately, all outputs 0, new CLR accepted after release.
